// File: rtl/shiftreg_pkg.sv
// Shared definitions for the 59-bit serial configuration chain sequencer.
package shiftreg_pkg;

    localparam int SR_N = 59;
    localparam int SR_NFIELD = 16;

    // Chain fields listed from MSB to LSB
    localparam int SR_FIELD_W [SR_NFIELD] = '{
        7, 1, 6, 1, 5, 1, 5, 1, 10, 1, 4, 1, 7, 1, 7, 1
    };
    localparam int SR_FIELD_LSB [SR_NFIELD] = '{
        52, 51, 45, 44, 39, 38, 33, 32, 22, 21, 17, 16, 9, 8, 1, 0
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LATCH,
        ST_DONE
    } state_t;

endpackage

// File: rtl/shiftreg_loader_sclk_phase_gen.sv
// Divider for the sclk half-periods; ticks on the last clk of each phase.
module sclk_phase_gen
    import shiftreg_pkg::*;
#(
    parameter int CLKDIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic phase_last
);

    localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

    logic [DW-1:0] cnt;

    assign phase_last = en && (cnt == DW'(CLKDIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || phase_last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DW'(1);
        end
    end

endmodule

// File: rtl/shiftreg_loader.sv
// Serializes a parallel config word into the chain MSB-first, latches it,
// and returns the previous chain contents as readback.
module shiftreg_loader
    import shiftreg_pkg::*;
#(
    parameter int N         = SR_N,
    parameter int CLKDIV    = 4,
    parameter int LATCH_CYC = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] cfg_data,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] rd_data,
    output logic         sclk,
    output logic         sdin,
    output logic         latch,
    input  logic         sr_out
);

    localparam int BW = $clog2(N);
    localparam int LW = $clog2(LATCH_CYC + 1);

    state_t        state;
    logic [N-1:0]  shreg;
    logic [N-1:0]  rb;
    logic [BW-1:0] bitcnt;
    logic [LW-1:0] lcnt;
    logic          phase_en;
    logic          phase_last;

    assign phase_en = (state == ST_SHIFT_LO) || (state == ST_SHIFT_HI);

    sclk_phase_gen #(
        .CLKDIV(CLKDIV)
    ) u_phase (
        .clk       (clk),
        .rst       (rst),
        .en        (phase_en),
        .phase_last(phase_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            sclk      <= 1'b0;
            sdin      <= 1'b0;
            latch     <= 1'b0;
            rd_data   <= '0;
            shreg     <= '0;
            rb        <= '0;
            bitcnt    <= '0;
            lcnt      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        state     <= ST_SHIFT_LO;
                        cfg_ready <= 1'b0;
                        busy      <= 1'b1;
                        sdin      <= cfg_data[N-1];
                        shreg     <= {cfg_data[N-2:0], 1'b0};
                        bitcnt    <= BW'(N - 1);
                    end
                end
                ST_SHIFT_LO: begin
                    // Chain MSB is sampled just before sclk rises
                    if (phase_last) begin
                        rb    <= {rb[N-2:0], sr_out};
                        sclk  <= 1'b1;
                        state <= ST_SHIFT_HI;
                    end
                end
                ST_SHIFT_HI: begin
                    if (phase_last) begin
                        sclk <= 1'b0;
                        if (bitcnt == '0) begin
                            state <= ST_LATCH;
                            latch <= 1'b1;
                            lcnt  <= '0;
                        end else begin
                            bitcnt <= bitcnt - BW'(1);
                            sdin   <= shreg[N-1];
                            shreg  <= {shreg[N-2:0], 1'b0};
                            state  <= ST_SHIFT_LO;
                        end
                    end
                end
                ST_LATCH: begin
                    if (lcnt == LW'(LATCH_CYC - 1)) begin
                        latch   <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rd_data <= rb;
                        state   <= ST_DONE;
                    end else begin
                        lcnt <= lcnt + LW'(1);
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    cfg_ready <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
